// File: rtl/fpga_ram_arbiter_if.sv
// ---------------------------------------------------------------------------
// fpga_ram_arbiter_if
// Bundles the two requester ports (s0, s1) and the single-port RAM port that
// the arbiter shares between them.
//   slave  modport : the arbiter's view (requester commands and RAM q in,
//                    stalls, read returns and RAM strobes out)
//   master modport : the surrounding system's view (requesters plus RAM)
// Parameters: ADDR_W word-address width, DATA_W data width (DATA_W/8 lanes).
// ---------------------------------------------------------------------------
interface fpga_ram_arbiter_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    // Requester port 0
    logic [ADDR_W-1:0]   s0_address;
    logic                s0_read;
    logic                s0_write;
    logic [DATA_W/8-1:0] s0_byteenable;
    logic [DATA_W-1:0]   s0_writedata;
    logic                s0_waitrequest;
    logic [DATA_W-1:0]   s0_readdata;
    logic                s0_readdatavalid;

    // Requester port 1
    logic [ADDR_W-1:0]   s1_address;
    logic                s1_read;
    logic                s1_write;
    logic [DATA_W/8-1:0] s1_byteenable;
    logic [DATA_W-1:0]   s1_writedata;
    logic                s1_waitrequest;
    logic [DATA_W-1:0]   s1_readdata;
    logic                s1_readdatavalid;

    // Shared RAM port
    logic [ADDR_W-1:0]   ram_address;
    logic [DATA_W/8-1:0] ram_byteenable;
    logic [DATA_W-1:0]   ram_writedata;
    logic                ram_chipselect;
    logic                ram_write;
    logic                ram_clken;
    logic [DATA_W-1:0]   ram_readdata;
    logic                ram_reset_req;

    modport slave (
        input  s0_address, s0_read, s0_write, s0_byteenable, s0_writedata,
        input  s1_address, s1_read, s1_write, s1_byteenable, s1_writedata,
        input  ram_readdata, ram_reset_req,
        output s0_waitrequest, s0_readdata, s0_readdatavalid,
        output s1_waitrequest, s1_readdata, s1_readdatavalid,
        output ram_address, ram_byteenable, ram_writedata,
        output ram_chipselect, ram_write, ram_clken
    );

    modport master (
        output s0_address, s0_read, s0_write, s0_byteenable, s0_writedata,
        output s1_address, s1_read, s1_write, s1_byteenable, s1_writedata,
        output ram_readdata, ram_reset_req,
        input  s0_waitrequest, s0_readdata, s0_readdatavalid,
        input  s1_waitrequest, s1_readdata, s1_readdatavalid,
        input  ram_address, ram_byteenable, ram_writedata,
        input  ram_chipselect, ram_write, ram_clken
    );
endinterface

// File: rtl/fpga_ram_arbiter.sv
// ---------------------------------------------------------------------------
// fpga_ram_arbiter
// Shares one single-port RAM (registered address, unregistered q) between two
// requesters. One command is granted per cycle, chosen combinationally from
// the live requests and the last granted port; the granted command is muxed
// onto the RAM with no added latency. Read data returns one cycle later on the
// port that issued the read. ram_reset_req stalls all new grants.
// Ports:
//   clk      single clock
//   reset_n  asynchronous active-low reset
//   bus      fpga_ram_arbiter_if.slave (s0/s1 requesters and RAM port)
// Parameters:
//   ADDR_W  word-address width, DATA_W data width
//   RR_EN   1: round-robin between s0/s1, 0: fixed priority to s0
// ---------------------------------------------------------------------------
module fpga_ram_arbiter #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32,
    parameter int RR_EN  = 1
) (
    input  logic                clk,
    input  logic                reset_n,
    fpga_ram_arbiter_if.slave   bus
);
    logic req0, req1;
    logic gnt0, gnt1;
    logic gnt_any, gnt_wr;
    logic last_grant;   // 1 = s1 was granted last (reset value makes s0 win first)
    logic rd_pend;      // a read was granted last cycle; its data is on ram_readdata now
    logic rd_owner;     // port that issued the pending read (1 = s1)
    logic vld0, vld1;

    logic [ADDR_W-1:0] mux_address;
    logic [DATA_W-1:0] ret_data;

    assign req0 = bus.s0_read | bus.s0_write;
    assign req1 = bus.s1_read | bus.s1_write;

    // Grants are also gated by reset_n so that nothing reaches the RAM while
    // the block is held in reset, even though the requesters may be active.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can leave it unassigned and infer a latch.
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (reset_n && !bus.ram_reset_req) begin
            if (req0 && req1) begin
                // Round-robin: the port that did not win last time wins now.
                if ((RR_EN != 0) && (last_grant == 1'b0))
                    gnt1 = 1'b1;
                else
                    gnt0 = 1'b1;
            end else begin
                gnt0 = req0;
                gnt1 = req1;
            end
        end
    end

    assign gnt_any = gnt0 | gnt1;
    // Write wins over read when a port raises both strobes.
    assign gnt_wr  = (gnt0 & bus.s0_write) | (gnt1 & bus.s1_write);

    assign bus.s0_waitrequest = ~gnt0;
    assign bus.s1_waitrequest = ~gnt1;

    assign mux_address        = gnt1 ? bus.s1_address    : bus.s0_address;
    assign bus.ram_address    = mux_address;
    assign bus.ram_byteenable = gnt1 ? bus.s1_byteenable : bus.s0_byteenable;
    assign bus.ram_writedata  = gnt1 ? bus.s1_writedata  : bus.s0_writedata;
    assign bus.ram_chipselect = gnt_any;
    assign bus.ram_write      = gnt_wr;
    assign bus.ram_clken      = ~bus.ram_reset_req;

    // The RAM q is unregistered, so data for last cycle's read is on
    // ram_readdata now; route it to the owner and zero the other port.
    assign vld0     = rd_pend & ~rd_owner;
    assign vld1     = rd_pend &  rd_owner;
    assign ret_data = bus.ram_readdata;

    assign bus.s0_readdatavalid = vld0;
    assign bus.s1_readdatavalid = vld1;
    assign bus.s0_readdata      = vld0 ? ret_data : '0;
    assign bus.s1_readdata      = vld1 ? ret_data : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant <= 1'b1;
            rd_pend    <= 1'b0;
            rd_owner   <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
            rd_pend <= gnt_any & ~gnt_wr;
            if (gnt_any)
                last_grant <= gnt1;
            if (gnt_any && !gnt_wr)
                rd_owner <= gnt1;
        end
    end
endmodule

// File: tb/tb_fpga_ram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fpga_ram_arbiter
// Two arbiters (round-robin and fixed priority) share one stimulus stream,
// each with its own RAM model. A behavioural model built from the arbitration
// rules predicts grants, RAM strobes and read returns every cycle.
// ---------------------------------------------------------------------------
module tb_fpga_ram_arbiter;
    localparam int AW = 10;
    localparam int DW = 32;
    localparam int BW = DW / 8;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    // Common stimulus
    logic          r0 = 0, w0 = 0, r1 = 0, w1 = 0, rrq = 0;
    logic [AW-1:0] a0 = '0, a1 = '0;
    logic [BW-1:0] be0 = '0, be1 = '0;
    logic [DW-1:0] d0 = '0, d1 = '0;

    fpga_ram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus_rr ();
    fpga_ram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus_fx ();

    fpga_ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RR_EN(1)) dut_rr (
        .clk(clk), .reset_n(reset_n), .bus(bus_rr));
    fpga_ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RR_EN(0)) dut_fx (
        .clk(clk), .reset_n(reset_n), .bus(bus_fx));

    assign bus_rr.s0_address = a0;  assign bus_fx.s0_address = a0;
    assign bus_rr.s0_read = r0;     assign bus_fx.s0_read = r0;
    assign bus_rr.s0_write = w0;    assign bus_fx.s0_write = w0;
    assign bus_rr.s0_byteenable = be0; assign bus_fx.s0_byteenable = be0;
    assign bus_rr.s0_writedata = d0;   assign bus_fx.s0_writedata = d0;
    assign bus_rr.s1_address = a1;  assign bus_fx.s1_address = a1;
    assign bus_rr.s1_read = r1;     assign bus_fx.s1_read = r1;
    assign bus_rr.s1_write = w1;    assign bus_fx.s1_write = w1;
    assign bus_rr.s1_byteenable = be1; assign bus_fx.s1_byteenable = be1;
    assign bus_rr.s1_writedata = d1;   assign bus_fx.s1_writedata = d1;
    assign bus_rr.ram_reset_req = rrq; assign bus_fx.ram_reset_req = rrq;

    // RAM models: registered address, unregistered q, byte-lane writes.
    logic [DW-1:0] mem_rr [1024];
    logic [DW-1:0] mem_fx [1024];
    logic [AW-1:0] areg_rr = '0, areg_fx = '0;

    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem_rr[i] = '0;
            mem_fx[i] = '0;
        end
    end

    always @(posedge clk) begin
        if (bus_rr.ram_chipselect && bus_rr.ram_clken) begin
            areg_rr <= bus_rr.ram_address;
            if (bus_rr.ram_write)
                for (int b = 0; b < BW; b++)
                    if (bus_rr.ram_byteenable[b])
                        mem_rr[bus_rr.ram_address][b*8 +: 8] <= bus_rr.ram_writedata[b*8 +: 8];
        end
        if (bus_fx.ram_chipselect && bus_fx.ram_clken) begin
            areg_fx <= bus_fx.ram_address;
            if (bus_fx.ram_write)
                for (int b = 0; b < BW; b++)
                    if (bus_fx.ram_byteenable[b])
                        mem_fx[bus_fx.ram_address][b*8 +: 8] <= bus_fx.ram_writedata[b*8 +: 8];
        end
    end
    assign bus_rr.ram_readdata = mem_rr[areg_rr];
    assign bus_fx.ram_readdata = mem_fx[areg_fx];

    // ----------------------------------------------------------------------
    // Checking
    // ----------------------------------------------------------------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic          w0, w1, cs, wr, clken, v0, v1;
        logic [AW-1:0] addr;
        logic [BW-1:0] be;
        logic [DW-1:0] wd, rd0, rd1;
    } obs_t;

    function automatic obs_t get_obs(input int k);
        obs_t o;
        if (k == 0) begin
            o.w0 = bus_rr.s0_waitrequest; o.w1 = bus_rr.s1_waitrequest;
            o.cs = bus_rr.ram_chipselect; o.wr = bus_rr.ram_write;
            o.clken = bus_rr.ram_clken;
            o.v0 = bus_rr.s0_readdatavalid; o.v1 = bus_rr.s1_readdatavalid;
            o.addr = bus_rr.ram_address; o.be = bus_rr.ram_byteenable;
            o.wd = bus_rr.ram_writedata;
            o.rd0 = bus_rr.s0_readdata; o.rd1 = bus_rr.s1_readdata;
        end else begin
            o.w0 = bus_fx.s0_waitrequest; o.w1 = bus_fx.s1_waitrequest;
            o.cs = bus_fx.ram_chipselect; o.wr = bus_fx.ram_write;
            o.clken = bus_fx.ram_clken;
            o.v0 = bus_fx.s0_readdatavalid; o.v1 = bus_fx.s1_readdatavalid;
            o.addr = bus_fx.ram_address; o.be = bus_fx.ram_byteenable;
            o.wd = bus_fx.ram_writedata;
            o.rd0 = bus_fx.s0_readdata; o.rd1 = bus_fx.s1_readdata;
        end
        return o;
    endfunction

    // Reference model state, one slot per arbiter (0 = round-robin, 1 = fixed).
    logic [DW-1:0] shadow [2][1024];
    int            m_last  [2] = '{1, 1};   // index of the port served most recently
    bit            m_pend  [2] = '{0, 0};
    int            m_owner [2] = '{0, 0};
    logic [DW-1:0] m_data  [2];
    int            cnt_valid [2][2];
    int            cnt_fx_w1_low = 0;

    initial begin
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 1024; i++)
                shadow[k][i] = '0;
    end

    function automatic int grant_code(input obs_t o);
        if (!o.w0) return 1;
        if (!o.w1) return 2;
        return 0;
    endfunction

    task automatic model_check(input int k, input int exp_tbl);
        obs_t          o;
        string         t;
        int            g;
        bit            req0, req1, is_wr;
        logic [AW-1:0] ga;
        logic [BW-1:0] gb;
        logic [DW-1:0] gd;
        o = get_obs(k);
        t = (k == 0) ? "rr" : "fx";
        if (!reset_n) begin
            m_pend[k] = 0;
            m_last[k] = 1;
        end
        req0 = r0 | w0;
        req1 = r1 | w1;
        if (!reset_n || rrq)      g = 0;
        else if (req0 && req1)    g = (k == 0) ? ((m_last[k] == 0) ? 2 : 1) : 1;
        else if (req0)            g = 1;
        else if (req1)            g = 2;
        else                      g = 0;
        is_wr = (g == 1) ? w0 : (g == 2) ? w1 : 1'b0;
        ga = (g == 2) ? a1 : a0;
        gb = (g == 2) ? be1 : be0;
        gd = (g == 2) ? d1 : d0;

        if (exp_tbl >= 0)
            check({t, ".tbl_grant"}, 64'(grant_code(o)), 64'(exp_tbl));
        check({t, ".s0_waitrequest"}, 64'(o.w0), 64'(g != 1));
        check({t, ".s1_waitrequest"}, 64'(o.w1), 64'(g != 2));
        check({t, ".ram_chipselect"}, 64'(o.cs), 64'(g != 0));
        check({t, ".ram_write"}, 64'(o.wr), 64'(is_wr));
        check({t, ".ram_clken"}, 64'(o.clken), 64'(!rrq));
        check({t, ".s0_readdatavalid"}, 64'(o.v0), 64'(m_pend[k] && m_owner[k] == 0));
        check({t, ".s1_readdatavalid"}, 64'(o.v1), 64'(m_pend[k] && m_owner[k] == 1));
        check({t, ".s0_readdata"}, 64'(o.rd0), (m_pend[k] && m_owner[k] == 0) ? 64'(m_data[k]) : 64'd0);
        check({t, ".s1_readdata"}, 64'(o.rd1), (m_pend[k] && m_owner[k] == 1) ? 64'(m_data[k]) : 64'd0);
        if (g != 0) begin
            check({t, ".ram_address"}, 64'(o.addr), 64'(ga));
            if (is_wr) begin
                check({t, ".ram_byteenable"}, 64'(o.be), 64'(gb));
                check({t, ".ram_writedata"}, 64'(o.wd), 64'(gd));
            end
        end
        if (o.v0) cnt_valid[k][0]++;
        if (o.v1) cnt_valid[k][1]++;
        if (k == 1 && !o.w1) cnt_fx_w1_low++;

        // Advance the model to what the next cycle should look like.
        m_pend[k] = 0;
        if (g != 0) begin
            m_last[k] = g - 1;
            if (is_wr) begin
                for (int b = 0; b < BW; b++)
                    if (gb[b]) shadow[k][ga][b*8 +: 8] = gd[b*8 +: 8];
            end else begin
                m_pend[k]  = 1;
                m_owner[k] = g - 1;
                m_data[k]  = shadow[k][ga];
            end
        end
    endtask

    // One clock cycle: check mid-cycle, then leave #1 after the next edge.
    task automatic step(input int exp_rr, input int exp_fx);
        @(negedge clk);
        model_check(0, exp_rr);
        model_check(1, exp_fx);
        @(posedge clk);
        #1;
    endtask

    task automatic set_cmd(input logic rd0_i, input logic wr0_i, input logic rd1_i, input logic wr1_i);
        r0 = rd0_i; w0 = wr0_i; r1 = rd1_i; w1 = wr1_i;
    endtask

    task automatic do_reset();
        set_cmd(0, 0, 0, 0);
        rrq = 0;
        reset_n = 0;
        step(0, 0);
        step(0, 0);
        reset_n = 1;
    endtask

    typedef struct {
        logic r0, w0, r1, w1, rrq;
        int   g_rr, g_fx;   // expected grant: 0 none, 1 s0, 2 s1
    } vec_t;

    vec_t tbl [12];

    initial begin
        // Sequential vectors from reset (last_grant starts at s1 side, so s0 wins first).
        tbl[0]  = '{1, 0, 1, 0, 0, 1, 1};
        tbl[1]  = '{1, 0, 1, 0, 0, 2, 1};
        tbl[2]  = '{0, 0, 0, 1, 0, 2, 2};
        tbl[3]  = '{0, 1, 0, 1, 0, 1, 1};
        tbl[4]  = '{1, 0, 1, 0, 1, 0, 0};
        tbl[5]  = '{1, 0, 1, 0, 0, 2, 1};
        tbl[6]  = '{0, 0, 0, 0, 0, 0, 0};
        tbl[7]  = '{1, 1, 0, 0, 0, 1, 1};
        tbl[8]  = '{1, 0, 0, 1, 0, 2, 1};
        tbl[9]  = '{1, 0, 0, 0, 0, 1, 1};
        tbl[10] = '{0, 0, 1, 0, 1, 0, 0};
        tbl[11] = '{0, 1, 1, 0, 0, 2, 1};

        do_reset();

        for (int i = 0; i < 12; i++) begin
            set_cmd(tbl[i].r0, tbl[i].w0, tbl[i].r1, tbl[i].w1);
            rrq = tbl[i].rrq;
            a0 = AW'(i); a1 = AW'(i + 16);
            be0 = 4'hF; be1 = 4'hF;
            d0 = 32'hC000_0000 + i; d1 = 32'hD000_0000 + i;
            step(tbl[i].g_rr, tbl[i].g_fx);
        end
        set_cmd(0, 0, 0, 0); rrq = 0;
        step(0, 0);

        // s0 write then read back the same word.
        a0 = 10'h005; d0 = 32'hA5A5_1234; be0 = 4'hF;
        set_cmd(0, 1, 0, 0); step(1, 1);
        set_cmd(1, 0, 0, 0); step(1, 1);
        set_cmd(0, 0, 0, 0); #1;
        check("rr.wr_rd_valid", 64'(bus_rr.s0_readdatavalid), 64'd1);
        check("rr.wr_rd_data", 64'(bus_rr.s0_readdata), 64'hA5A5_1234);
        step(0, 0);

        // s1 partial-lane write over 0x1111_1111.
        a1 = 10'h007; d1 = 32'h1111_1111; be1 = 4'hF;
        set_cmd(0, 0, 0, 1); step(2, 2);
        d1 = 32'hFFFF_FFFF; be1 = 4'h3;
        step(2, 2);
        set_cmd(0, 0, 1, 0); step(2, 2);
        set_cmd(0, 0, 0, 0); #1;
        check("fx.be_merge_data", 64'(bus_fx.s1_readdata), 64'h1111_FFFF);
        step(0, 0);

        // Both ports read every cycle for 8 cycles.
        do_reset();
        for (int k = 0; k < 2; k++) begin
            cnt_valid[k][0] = 0;
            cnt_valid[k][1] = 0;
        end
        cnt_fx_w1_low = 0;
        set_cmd(1, 0, 1, 0);
        for (int i = 0; i < 8; i++) begin
            a0 = AW'(i); a1 = AW'(i + 8);
            step((i % 2 == 0) ? 1 : 2, 1);
        end
        set_cmd(0, 0, 0, 0);
        step(0, 0);
        check("rr.s0_returns", 64'(cnt_valid[0][0]), 64'd4);
        check("rr.s1_returns", 64'(cnt_valid[0][1]), 64'd4);
        check("fx.s0_returns", 64'(cnt_valid[1][0]), 64'd8);
        check("fx.s1_returns", 64'(cnt_valid[1][1]), 64'd0);
        check("fx.s1_never_granted", 64'(cnt_fx_w1_low), 64'd0);

        // RAM reset request for 3 cycles with both ports requesting.
        set_cmd(1, 0, 1, 0);
        rrq = 1;
        for (int i = 0; i < 3; i++) step(0, 0);
        rrq = 0;
        step(1, 1);

        // Pending read survives a RAM reset request.
        set_cmd(0, 0, 1, 0); a1 = 10'h00A;
        step(2, 2);
        set_cmd(1, 0, 1, 0); rrq = 1; #1;
        check("rr.pend_through_rrq", 64'(bus_rr.s1_readdatavalid), 64'd1);
        step(0, 0);
        rrq = 0;
        set_cmd(0, 0, 0, 0);
        step(-1, -1);

        // Reset asserted the cycle after an s0 read grant.
        set_cmd(1, 0, 0, 0); a0 = 10'h005;
        step(1, 1);
        reset_n = 0;
        set_cmd(1, 0, 1, 0); #1;
        check("rr.reset_drops_read", 64'(bus_rr.s0_readdatavalid), 64'd0);
        check("fx.reset_drops_read", 64'(bus_fx.s0_readdatavalid), 64'd0);
        step(0, 0);
        step(0, 0);
        reset_n = 1;
        step(1, 1);
        set_cmd(0, 0, 0, 0);
        step(-1, -1);

        // Randomized traffic, including high addresses, RAM resets and resets.
        for (int i = 0; i < 600; i++) begin
            r0 = ($urandom_range(0, 2) != 0);
            w0 = ($urandom_range(0, 2) == 0);
            r1 = ($urandom_range(0, 2) != 0);
            w1 = ($urandom_range(0, 2) == 0);
            rrq = ($urandom_range(0, 7) == 0);
            reset_n = ($urandom_range(0, 63) != 0);
            a0 = ($urandom_range(0, 3) == 0) ? AW'(10'h3F0 + $urandom_range(0, 15)) : AW'($urandom_range(0, 15));
            a1 = ($urandom_range(0, 3) == 0) ? AW'(10'h3F0 + $urandom_range(0, 15)) : AW'($urandom_range(0, 15));
            be0 = BW'($urandom); be1 = BW'($urandom);
            d0 = $urandom; d1 = $urandom;
            step(-1, -1);
        end
        reset_n = 1;
        set_cmd(0, 0, 0, 0); rrq = 0;
        step(-1, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fpga_ram_arbiter.md
FPGA_RAM_ARBITER -- requirements
Module: fpga_ram_arbiter

Interface
REQ-001 The block SHALL provide parameter ADDR_W, default 10, meaning the word-address width of the shared RAM.
REQ-002 The block SHALL provide parameter DATA_W, default 32, meaning the data width; byteenable width is DATA_W/8.
REQ-003 The block SHALL provide parameter RR_EN, default 1, meaning round-robin when 1 and fixed priority to port s0 when 0.
REQ-004 clk  input  1  single clock for all logic.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 s0_address, s1_address  input  ADDR_W  requester word addresses.
REQ-007 s0_read/s0_write, s1_read/s1_write  input  1 each  requester read and write strobes.
REQ-008 s0_byteenable, s1_byteenable  input  DATA_W/8  write byte lanes.
REQ-009 s0_writedata, s1_writedata  input  DATA_W  write data.
REQ-010 s0_waitrequest, s1_waitrequest  output  1 each  stall; low means the command is accepted this cycle.
REQ-011 s0_readdata/s0_readdatavalid, s1_readdata/s1_readdatavalid  output  DATA_W/1  read return.
REQ-012 ram_address  output  ADDR_W  address to the single-port RAM.
REQ-013 ram_byteenable, ram_writedata  output  DATA_W/8, DATA_W  write byte lanes and data to the RAM.
REQ-014 ram_chipselect, ram_write  output  1  RAM strobes.
REQ-015 ram_clken  output  1  RAM clock enable.
REQ-016 ram_readdata  input  DATA_W  RAM output; unregistered q, valid the cycle after the address edge.
REQ-017 ram_reset_req  input  1  RAM reset request; when high, the arbiter stalls all traffic.

Function
REQ-018 A port SHALL request when read or write is high; if both are high, the access SHALL be treated as a write.
REQ-019 At most one grant SHALL be issued per cycle, and a grant SHALL be issued only when ram_reset_req is low.
REQ-020 Arbitration SHALL be combinational from the current requests and the last_grant register (1 bit, reset 1, so s0 wins first).
REQ-021 With RR_EN=1 and both ports requesting, the port not equal to last_grant SHALL win.
REQ-022 With RR_EN=0 and both ports requesting, s0 SHALL always win.
REQ-023 last_grant SHALL update only on a cycle in which a grant is issued.
REQ-024 The granted port SHALL see waitrequest low in the grant cycle; every other requesting port SHALL see waitrequest high.
REQ-025 A non-requesting port SHALL see waitrequest high.
REQ-026 The RAM address, byteenable and writedata outputs SHALL mux the granted port's signals with zero added latency.
REQ-027 ram_chipselect SHALL be high on any grant and ram_write SHALL be high on a write grant.
REQ-028 ram_clken SHALL equal ~ram_reset_req.
REQ-029 On a read grant, a 1-bit rd_pend register and a 1-bit rd_owner register SHALL capture the read and its owner.
REQ-030 In the cycle after a read grant, readdatavalid of rd_owner SHALL be high for exactly one cycle.
REQ-031 That port's readdata SHALL equal ram_readdata; a port's readdata SHALL be zero when its readdatavalid is low.
REQ-032 Read latency SHALL be exactly 1 cycle, and back-to-back reads SHALL sustain 1 per cycle with no bubble.
REQ-033 A write SHALL complete in its grant cycle and SHALL NOT produce readdatavalid.
REQ-034 A read issued the cycle after a write to the same address SHALL return the new data.
REQ-035 When ram_reset_req rises while a read is pending, the pending readdatavalid SHALL still be delivered.
REQ-036 Address width SHALL pass through unchanged, with no address wrap or translation.

Reset
REQ-037 While reset_n is low, last_grant=1 and rd_pend=0, all readdatavalid=0, all readdata=0, waitrequest=1 on both ports, and ram_chipselect=0 and ram_write=0.
REQ-038 Reset assertion mid-read SHALL discard the pending return; no readdatavalid SHALL appear after reset release.
REQ-039 The first cycle after reset release SHALL arbitrate normally.

Verification
REQ-040 s0 write addr 0x005 data 0xA5A5_1234 be 0xF, then s0 read 0x005 -> s0_readdatavalid one cycle after the read grant, data 0xA5A5_1234.
REQ-041 Both ports read every cycle for 8 cycles, RR_EN=1 -> grants alternate s0,s1,s0,...; each port receives 4 valid returns, routed to the correct port.
REQ-042 Same stimulus with RR_EN=0 -> s0 granted all 8 cycles; s1_waitrequest held high throughout.
REQ-043 s1 write be 0x3 data 0xFFFF_FFFF to a word holding 0x1111_1111 -> a subsequent read returns 0x1111_FFFF.
REQ-044 ram_reset_req high for 3 cycles with both ports requesting -> no grants, ram_clken=0, and waitrequest high on both ports; arbitration resumes the cycle after it drops.
REQ-045 reset_n asserted the cycle after an s0 read grant -> no s0_readdatavalid; after release, s0 wins the first contested grant.
